lsu_axil_master: RTL and testbench
==================================

// Module: lsu_axil_master
// PURPOSE
//  Core-side initiator for the data-memory path. Accepts one RV32 load/store request
//  (address, func3, store data) and issues it as a single AXI4-Lite master transaction.
//  Builds byte lanes and WSTRB for SB/SH/SW; sign- or zero-extends read data for
//  LB/LH/LW/LBU/LHU. Sits between the pipeline MEM stage and the AXI4-Lite data slave.
//  Strictly one transaction outstanding.
// PARAMETERS
//  ADDR_W  32  width of req_addr, m_awaddr and m_araddr
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       1 only in IDLE; a request is accepted on req_valid & req_ready
//  req_we     in   1       1 = store, 0 = load
//  req_func3  in   3       RV32 func3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, LSB-aligned
//  rsp_valid  out  1       one-cycle response pulse
//  rsp_rdata  out  32      extended load data; 0 for stores and errors
//  rsp_err    out  1       bad func3, misaligned access (macro) or RESP[1] set
//  m_awaddr/m_awvalid/m_awready   out/out/in  ADDR_W/1/1  AW channel
//  m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  W channel
//  m_bresp/m_bvalid/m_bready      in/in/out   2/1/1       B channel
//  m_araddr/m_arvalid/m_arready   out/out/in  ADDR_W/1/1  AR channel
//  m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  R channel
// BEHAVIOUR
//  Reset: state IDLE; all m_*valid, m_bready, m_rready, rsp_valid, rsp_err = 0;
//   rsp_rdata = 0. A reset mid-transaction abandons it; no response is issued.
//  States: IDLE, AR, R, AWW, B, RSP.
//  IDLE: on accept, register addr/func3/wdata.
//   - Load goes to AR; store goes to AWW.
//   - Illegal func3 goes straight to RSP with rsp_err=1 and no bus activity.
//     Illegal for loads: 011/110/111. Illegal for stores: any value > 010.
//  Bus addresses are {addr[ADDR_W-1:2], 2'b00}.
//  AR: m_arvalid=1, held stable until m_arready, then go to R.
//  R: m_rready=1; on m_rvalid, capture data and err=m_rresp[1], then go to RSP.
//  AWW: m_awvalid and m_wvalid rise together. Each drops independently after its own
//   handshake; go to B once both have completed (either order, or same cycle).
//  B: m_bready=1; on m_bvalid, err=m_bresp[1], then go to RSP.
//  RSP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in this state.
//  Store lanes, with o = addr[1:0]:
//   - SB: wdata {4{d[7:0]}}, wstrb 0001<<o
//   - SH: wdata {2{d[15:0]}}, wstrb 0011<<{o[1],1'b0}
//   - SW: wdata d, wstrb 1111
//  Load extraction: LB/LBU select byte o; LH/LHU select half o[1]; LW takes the full
//   word. LB/LH sign-extend; LBU/LHU zero-extend. rsp_rdata=0 whenever rsp_err=1.
//  Latency with a zero-wait slave: accept in cycle 0, address handshake in cycle 1,
//   R/B handshake in cycle 2, rsp_valid in cycle 3. Back-to-back throughput is one
//   request per 4 cycles. Illegal func3: rsp_valid in cycle 1.
//  Outputs only change on a clock edge. No combinational path from m_* inputs to any
//   m_* output.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: an H access with addr[0]=1, or a W access with
//   addr[1:0]!=0, goes IDLE->RSP with rsp_err=1 and no bus transaction.
//  Not defined: no alignment check; low address bits are ignored as given by the lane
//   rules above (SH uses o[1], LW ignores o).
// TESTING
//  SW 0x100 = 0xDEADBEEF, zero-wait slave -> AW/W in cycle 1 with wstrb=1111;
//   rsp_valid in cycle 3, err=0.
//  SB 0x103 d=0x5A -> awaddr 0x100, wdata 0x5A5A5A5A, wstrb 1000.
//  LB / LBU at 0x102, rdata 0x0080FF00 -> rsp_rdata 0xFFFFFF80 / 0x00000080.
//  LHU at 0x102, rdata 0x8001xxxx, arready delayed 3 cycles and wready before awready
//   -> araddr held stable until handshake; rsp_rdata 0x00008001.
//   Separate store: wready before awready -> AW and W complete independently;
//   exactly one B awaited.
//  func3=011 load; then an LW with rresp=2'b10 -> each gives rsp_err=1, rsp_rdata=0.
//   The func3=011 load issues no AR.
//  rst asserted while in R -> next cycle all valids 0 and state IDLE; no rsp_valid.
//   With the macro: LW 0x101 -> rsp_err=1 and no arvalid.

Source files
------------

// File: rtl/lsu_axil_master.sv
// lsu_axil_master: RV32 load/store unit front-end that turns one core request into a
// single AXI4-Lite master transaction, with byte-lane steering for stores and
// sign/zero extension for loads. One transaction outstanding at a time.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned halfword
// and word accesses are answered with an error and never reach the bus.
module lsu_axil_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // core request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    // AXI4-Lite write data
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    // AXI4-Lite write response
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    // AXI4-Lite read data
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        func3_q, func3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              illegal;
    logic              misalign;
    logic [31:0]       rshift;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Low response bit carries no error meaning in AXI4-Lite (OKAY vs EXOKAY).
    logic              unused_resp_lsb;
    assign unused_resp_lsb = &{1'b0, m_rresp[0], m_bresp[0]};

    // Loads reject 011/110/111; stores reject anything beyond SW.
    assign illegal = req_we ? (req_func3 > 3'b010)
                            : ((req_func3 == 3'b011) || (req_func3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane selection for load data, driven by the captured offset.
    assign rshift   = m_rdata >> {addr_q[1:0], 3'b000};
    assign byte_sel = rshift[7:0];
    assign half_sel = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];

    // Sign/zero extension according to the captured func3.
    always_comb begin
        load_ext = m_rdata;
        case (func3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = m_rdata;
        endcase
    end

    // Next-state logic: request capture, channel handshakes and response formation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        func3_d   = func3_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    func3_d   = req_func3;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    rdata_d   = 32'h0;
                    wdata_d   = req_wdata;
                    wstrb_d   = 4'b0000;
                    if (req_we) begin
                        case (req_func3[1:0])
                            2'b00: begin
                                wdata_d = {4{req_wdata[7:0]}};
                                wstrb_d = 4'b0001 << req_addr[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{req_wdata[15:0]}};
                                wstrb_d = 4'b0011 << {req_addr[1], 1'b0};
                            end
                            default: begin
                                wdata_d = req_wdata;
                                wstrb_d = 4'b1111;
                            end
                        endcase
                    end
                    if (illegal || misalign) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        state_d = req_we ? S_AWW : S_AR;
                    end
                end
            end
            S_AR: begin
                if (m_arready) state_d = S_R;
            end
            S_R: begin
                if (m_rvalid) begin
                    err_d   = m_rresp[1];
                    rdata_d = m_rresp[1] ? 32'h0 : load_ext;
                    state_d = S_RSP;
                end
            end
            S_AWW: begin
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if ((aw_done_q | m_awready) && (w_done_q | m_wready)) state_d = S_B;
            end
            S_B: begin
                if (m_bvalid) begin
                    err_d   = m_bresp[1];
                    rdata_d = 32'h0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            func3_q   <= 3'b000;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            func3_q   <= func3_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs decode registered state only, so no bus input reaches a bus output.
    assign req_ready = (state_q == S_IDLE);
    assign m_arvalid = (state_q == S_AR);
    assign m_rready  = (state_q == S_R);
    assign m_awvalid = (state_q == S_AWW) && !aw_done_q;
    assign m_wvalid  = (state_q == S_AWW) && !w_done_q;
    assign m_bready  = (state_q == S_B);
    assign m_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_err   = (state_q == S_RSP) && err_q;
    assign rsp_rdata = (state_q == S_RSP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master: drives inputs on the falling edge and samples
// outputs there, so every observation sits half a cycle away from the active edge.
module tb_lsu_axil_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    lsu_axil_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Store against a zero-wait slave: AW/W in cycle 1, B in cycle 2, response in cycle 3.
    task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] d, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_strb, input logic [1:0] bresp,
                            input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = f3; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".awvalid"}, 32'(m_awvalid), 32'd1);
        chk({tag, ".wvalid"},  32'(m_wvalid),  32'd1);
        chk({tag, ".awaddr"},  m_awaddr, a & 32'hFFFF_FFFC);
        chk({tag, ".wdata"},   m_wdata, exp_wdata);
        chk({tag, ".wstrb"},   32'(m_wstrb), 32'(exp_strb));
        @(negedge clk);
        chk({tag, ".bready"},  32'(m_bready), 32'd1);
        chk({tag, ".aw_drop"}, 32'({m_awvalid, m_wvalid}), 32'd0);
        m_bvalid = 1'b1; m_bresp = bresp;
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = 2'b00;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_err"},   32'(rsp_err), 32'(exp_err));
        chk({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, ".rdy_in_rsp"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".rsp_end"},   32'(rsp_valid), 32'd0);
        $display("store %s addr=0x%08h f3=%0d data=0x%08h done", tag, a, f3, d);
    endtask

    // Load against a zero-wait slave: AR in cycle 1, R in cycle 2, response in cycle 3.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [1:0] rresp,
                           input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = f3; req_addr = a; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".arvalid"}, 32'(m_arvalid), 32'd1);
        chk({tag, ".araddr"},  m_araddr, a & 32'hFFFF_FFFC);
        @(negedge clk);
        chk({tag, ".rready"},  32'(m_rready), 32'd1);
        m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
        @(negedge clk);
        m_rvalid = 1'b0; m_rresp = 2'b00;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_err"},   32'(rsp_err), 32'(exp_err));
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        @(negedge clk);
        chk({tag, ".rsp_end"},   32'(rsp_valid), 32'd0);
        $display("load %s addr=0x%08h f3=%0d rsp=0x%08h", tag, a, f3, rsp_rdata);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
        chk("rst.rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'h0);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        $display("reset released");

        // Stores with zero-wait slave
        do_store("SW100", 32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 2'b00, 1'b0);
        do_store("SB103", 32'h103, 3'b000, 32'h0000005A, 32'h5A5A5A5A, 4'b1000, 2'b00, 1'b0);
        do_store("SH102", 32'h102, 3'b001, 32'hAAAA1234, 32'h12341234, 4'b1100, 2'b00, 1'b0);
        do_store("SWslverr", 32'h104, 3'b010, 32'h01020304, 32'h01020304, 4'b1111, 2'b10, 1'b1);

        // Loads with zero-wait slave
        do_load("LB102",  32'h102, 3'b000, 32'h0080FF00, 2'b00, 32'hFFFFFF80, 1'b0);
        do_load("LBU102", 32'h102, 3'b100, 32'h0080FF00, 2'b00, 32'h00000080, 1'b0);
        do_load("LH100",  32'h100, 3'b001, 32'h1234F00D, 2'b00, 32'hFFFFF00D, 1'b0);
        do_load("LWerr",  32'h100, 3'b010, 32'hFFFFFFFF, 2'b10, 32'h00000000, 1'b1);

        // LHU with arready held low for three cycles
        m_arready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b101; req_addr = 32'h102;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("LHU.arvalid_hold", 32'(m_arvalid), 32'd1);
            chk("LHU.araddr_hold", m_araddr, 32'h100);
            @(negedge clk);
        end
        m_arready = 1'b1;
        chk("LHU.araddr_final", m_araddr, 32'h100);
        @(negedge clk);
        chk("LHU.ar_drop", 32'(m_arvalid), 32'd0);
        chk("LHU.rready", 32'(m_rready), 32'd1);
        m_rvalid = 1'b1; m_rdata = 32'h80011234;
        @(negedge clk);
        m_rvalid = 1'b0;
        chk("LHU.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("LHU.rsp_rdata", rsp_rdata, 32'h00008001);
        $display("load LHU102 delayed-ar rsp=0x%08h", rsp_rdata);

        // Store with W accepted before AW
        @(negedge clk);
        m_awready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        chk("WfirstAW.both_up", 32'({m_awvalid, m_wvalid}), 32'd3);
        @(negedge clk);
        chk("WfirstAW.w_dropped", 32'({m_awvalid, m_wvalid}), 32'd2);
        chk("WfirstAW.no_bready", 32'(m_bready), 32'd0);
        m_awready = 1'b1;
        @(negedge clk);
        chk("WfirstAW.aw_dropped", 32'({m_awvalid, m_wvalid}), 32'd0);
        chk("WfirstAW.bready", 32'(m_bready), 32'd1);
        m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0;
        chk("WfirstAW.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("WfirstAW.rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        chk("WfirstAW.one_b", 32'({m_bready, rsp_valid}), 32'd0);
        $display("store W-before-AW addr=0x00000200 done");

        // Illegal load func3 011: response in cycle 1, no AR
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b011; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ILL011.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ILL011.rsp_err", 32'(rsp_err), 32'd1);
        chk("ILL011.rsp_rdata", rsp_rdata, 32'h0);
        chk("ILL011.no_ar", 32'(m_arvalid), 32'd0);
        @(negedge clk);
        chk("ILL011.still_no_ar", 32'(m_arvalid), 32'd0);
        $display("load func3=011 rejected err=1");

        // Illegal store func3 100: response in cycle 1, no AW/W
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b100; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ILLST.rsp_err", 32'({rsp_valid, rsp_err}), 32'd3);
        chk("ILLST.no_aw", 32'({m_awvalid, m_wvalid}), 32'd0);
        @(negedge clk);
        $display("store func3=100 rejected err=1");

        // Reset while waiting in R
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("RSTR.in_r", 32'(m_rready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("RSTR.valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'd0);
        chk("RSTR.idle", 32'(req_ready), 32'd1);
        chk("RSTR.no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("RSTR.no_rsp_later", 32'(rsp_valid), 32'd0);
        $display("reset during R abandoned transaction");

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned LW traps without bus activity
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h101;
        @(negedge clk);
        req_valid = 1'b0;
        chk("MIS.rsp_err", 32'({rsp_valid, rsp_err}), 32'd3);
        chk("MIS.no_ar", 32'(m_arvalid), 32'd0);
        @(negedge clk);
        $display("load LW 0x101 trapped misaligned");
`else
        // Without the trap, low address bits are ignored for a word load
        do_load("LW101", 32'h101, 3'b010, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
